// File: rtl/sum_window_avg.sv
// Sums fixed windows of 2^LOG2_N qualified inputs and queues {rounded mean, total} in a 2-entry buffer.
// Result valid one cycle after the last sum of a window is accepted; no input backpressure, full-buffer results are dropped and flagged.
module sum_window_avg #(
  parameter  int IN_W   = 18,
  parameter  int LOG2_N = 2,
  localparam int TOT_W  = IN_W + LOG2_N
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [IN_W-1:0]   sum_in,
  input  logic              sum_valid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IN_W-1:0]   avg_out,
  output logic [TOT_W-1:0]  total_out,
  output logic [LOG2_N-1:0] win_cnt,
  output logic              drop_flag
);

  localparam logic [TOT_W-1:0] HALF = TOT_W'(1) << (LOG2_N - 1);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_e;

  buf_state_e        state_q;
  logic [TOT_W-1:0]  acc_q, acc_d;
  logic [LOG2_N-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]   head_avg_q, slot_avg_q;
  logic [TOT_W-1:0]  head_tot_q, slot_tot_q;
  logic              vld_q, drop_q;

  logic [TOT_W-1:0]  total_c;
  logic [IN_W-1:0]   avg_c;
  logic              push_c, pop_c;

  always_comb begin
    total_c = acc_q + TOT_W'(sum_in);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    push_c  = 1'b0;
    if (sum_valid) begin
      if (&cnt_q) begin
        acc_d  = '0;
        cnt_d  = '0;
        push_c = 1'b1;
      end else begin
        acc_d = total_c;
        cnt_d = cnt_q + LOG2_N'(1);
      end
    end
  end

  // The rounded mean of N values of IN_W bits always fits back into IN_W bits.
  assign avg_c = IN_W'((total_c + HALF) >> LOG2_N);
  assign pop_c = vld_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      acc_q      <= '0;
      cnt_q      <= '0;
      head_avg_q <= '0;
      head_tot_q <= '0;
      slot_avg_q <= '0;
      slot_tot_q <= '0;
      vld_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else if (clr) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      case (state_q)
        EMPTY: begin
          if (push_c) begin
            head_avg_q <= avg_c;
            head_tot_q <= total_c;
            vld_q      <= 1'b1;
            state_q    <= ONE;
          end
        end
        ONE: begin
          if (push_c && pop_c) begin
            head_avg_q <= avg_c;
            head_tot_q <= total_c;
          end else if (push_c) begin
            slot_avg_q <= avg_c;
            slot_tot_q <= total_c;
            state_q    <= FULL;
          end else if (pop_c) begin
            vld_q   <= 1'b0;
            state_q <= EMPTY;
          end
        end
        FULL: begin
          // A pop frees the slot in the same edge, so a simultaneous push still fits.
          if (pop_c) begin
            head_avg_q <= slot_avg_q;
            head_tot_q <= slot_tot_q;
            if (push_c) begin
              slot_avg_q <= avg_c;
              slot_tot_q <= total_c;
            end else begin
              state_q <= ONE;
            end
          end else if (push_c) begin
            drop_q <= 1'b1;
          end
        end
        default: begin
          state_q <= EMPTY;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = vld_q;
  assign avg_out   = head_avg_q;
  assign total_out = head_tot_q;
  assign win_cnt   = cnt_q;
  assign drop_flag = drop_q;

endmodule

// File: tb/tb_sum_window_avg.sv
// Bench for sum_window_avg: directed scenarios plus random traffic against a queue-based reference model.
module tb_sum_window_avg;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [17:0] sum_in = '0;
  logic        sum_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [17:0] avg_out;
  logic [19:0] total_out;
  logic [1:0]  win_cnt;
  logic        drop_flag;

  int checks = 0;
  int passed = 0;

  int unsigned m_win[$];
  logic [19:0] m_tot[$];
  logic [17:0] m_avg[$];
  bit          m_drop;
  logic [19:0] m_last_tot;
  logic [17:0] m_last_avg;
  bit          m_last_ok;

  always #5 clk = ~clk;

  sum_window_avg #(.IN_W(18), .LOG2_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sum_in(sum_in), .sum_valid(sum_valid),
    .out_valid(out_valid), .out_ready(out_ready), .avg_out(avg_out),
    .total_out(total_out), .win_cnt(win_cnt), .drop_flag(drop_flag)
  );

  task automatic model_reset();
    m_win.delete(); m_tot.delete(); m_avg.delete();
    m_drop = 0; m_last_tot = '0; m_last_avg = '0; m_last_ok = 1;
  endtask

  // Reference: a window is a list of sums; the output buffer is a queue of capacity 2.
  task automatic model_step(input bit v, input int unsigned s, input bit rdy, input bit c);
    int unsigned t;
    bit push;
    push = 0; t = 0;
    if (c) begin
      if (m_tot.size() > 0) m_last_ok = 0;
      m_win.delete(); m_tot.delete(); m_avg.delete(); m_drop = 0;
      return;
    end
    if (v) begin
      m_win.push_back(s);
      if (m_win.size() == N) begin
        foreach (m_win[i]) t += m_win[i];
        m_win.delete();
        push = 1;
      end
    end
    if (rdy && m_tot.size() > 0) begin
      m_last_tot = m_tot.pop_front();
      m_last_avg = m_avg.pop_front();
      m_last_ok  = 1;
    end
    if (push) begin
      if (m_tot.size() < 2) begin
        m_tot.push_back(20'(t));
        m_avg.push_back(18'((t + N / 2) / N));
      end else begin
        m_drop = 1;
      end
    end
  endtask

  task automatic cyc(input bit v, input int unsigned s, input bit rdy, input bit c);
    sum_valid = v; sum_in = 18'(s); out_ready = rdy; clr = c;
    model_step(v, s, rdy, c);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%0d exp=0", out_valid); else passed++;
    checks++; if (win_cnt !== 2'd0) $display("FAIL reset_wincnt got=%0d exp=0", win_cnt); else passed++;
    checks++; if (drop_flag !== 1'b0) $display("FAIL reset_drop got=%0d exp=0", drop_flag); else passed++;
    checks++; if (avg_out !== 18'd0) $display("FAIL reset_avg got=%0d exp=0", avg_out); else passed++;
    checks++; if (total_out !== 20'd0) $display("FAIL reset_total got=%0d exp=0", total_out); else passed++;
    rst_n = 1;
  endtask

  task automatic test_basic();
    int sums[4] = '{100, 200, 300, 401};
    int expw[4] = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, sums[i], 1, 0);
      checks++; if (win_cnt !== 2'(expw[i])) $display("FAIL basic_wincnt%0d got=%0d exp=%0d", i, win_cnt, expw[i]); else passed++;
    end
    checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid got=%0d exp=1", out_valid); else passed++;
    checks++; if (total_out !== 20'd1001) $display("FAIL basic_total got=%0d exp=1001", total_out); else passed++;
    checks++; if (avg_out !== 18'd250) $display("FAIL basic_avg got=%0d exp=250", avg_out); else passed++;
    cyc(0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL basic_valid_one_cycle got=%0d exp=0", out_valid); else passed++;
  endtask

  task automatic test_max_gaps();
    int pat[2][4] = '{'{1, 1, 1, 1}, '{1, 0, 0, 1}};
    int et[2] = '{4, 2};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 262143, 1, 0);
      if (i < 3) repeat (2) cyc(0, 0, 1, 0);
    end
    checks++; if (total_out !== 20'd1048572) $display("FAIL max_total got=%0d exp=1048572", total_out); else passed++;
    checks++; if (avg_out !== 18'd262143) $display("FAIL max_avg got=%0d exp=262143", avg_out); else passed++;
    cyc(0, 0, 1, 0);
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) cyc(1, pat[p][i], 1, 0);
      checks++; if (total_out !== 20'(et[p])) $display("FAIL round%0d_total got=%0d exp=%0d", p, total_out, et[p]); else passed++;
      checks++; if (avg_out !== 18'd1) $display("FAIL round%0d_avg got=%0d exp=1", p, avg_out); else passed++;
      cyc(0, 0, 1, 0);
    end
  endtask

  task automatic test_drop();
    for (int w = 1; w <= 3; w++)
      for (int i = 0; i < 4; i++) cyc(1, 10 * w, 0, 0);
    cyc(0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || total_out !== 20'd40) $display("FAIL drop_head got=%0d/%0d exp=1/40", out_valid, total_out); else passed++;
    checks++; if (drop_flag !== 1'b1) $display("FAIL drop_flag got=%0d exp=1", drop_flag); else passed++;
    cyc(0, 0, 1, 0);
    checks++; if (out_valid !== 1'b1 || total_out !== 20'd80) $display("FAIL drop_second got=%0d/%0d exp=1/80", out_valid, total_out); else passed++;
    cyc(0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL drop_drained got=%0d exp=0", out_valid); else passed++;
    checks++; if (drop_flag !== 1'b1) $display("FAIL drop_sticky got=%0d exp=1", drop_flag); else passed++;
    cyc(0, 0, 1, 1);
    checks++; if (drop_flag !== 1'b0) $display("FAIL drop_clr got=%0d exp=0", drop_flag); else passed++;
  endtask

  task automatic test_full_pushpop();
    for (int w = 1; w <= 2; w++)
      for (int i = 0; i < 4; i++) cyc(1, 10 * w, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 30, 0, 0);
    cyc(1, 30, 1, 0);
    checks++; if (out_valid !== 1'b1 || total_out !== 20'd80) $display("FAIL full_pp_head got=%0d/%0d exp=1/80", out_valid, total_out); else passed++;
    checks++; if (drop_flag !== 1'b0) $display("FAIL full_pp_drop got=%0d exp=0", drop_flag); else passed++;
    cyc(0, 0, 1, 0);
    checks++; if (out_valid !== 1'b1 || total_out !== 20'd120) $display("FAIL full_pp_third got=%0d/%0d exp=1/120", out_valid, total_out); else passed++;
    checks++; if (avg_out !== 18'd30) $display("FAIL full_pp_avg got=%0d exp=30", avg_out); else passed++;
    cyc(0, 0, 1, 0);
    checks++; if (out_valid !== 1'b0) $display("FAIL full_pp_drained got=%0d exp=0", out_valid); else passed++;
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) cyc(1, 5, 0, 0);
    cyc(1, 10, 0, 0);
    cyc(1, 20, 0, 0);
    cyc(1, 30, 1, 1);
    checks++; if (win_cnt !== 2'd0) $display("FAIL clr_wincnt got=%0d exp=0", win_cnt); else passed++;
    checks++; if (out_valid !== 1'b0) $display("FAIL clr_valid got=%0d exp=0", out_valid); else passed++;
    checks++; if (drop_flag !== 1'b0) $display("FAIL clr_drop got=%0d exp=0", drop_flag); else passed++;
    for (int i = 0; i < 4; i++) cyc(1, 4, 0, 0);
    checks++; if (total_out !== 20'd16 || avg_out !== 18'd4) $display("FAIL clr_next got=%0d/%0d exp=16/4", total_out, avg_out); else passed++;
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cyc(1, 3, 0, 0);
    cyc(1, 7, 0, 0);
    cyc(1, 7, 0, 0);
    sum_valid = 0;
    checks++; if (win_cnt !== 2'd2 || out_valid !== 1'b1) $display("FAIL arst_pre got=%0d/%0d exp=2/1", win_cnt, out_valid); else passed++;
    #3 rst_n = 0;
    model_reset();
    #1;
    checks++; if (out_valid !== 1'b0 || win_cnt !== 2'd0 || drop_flag !== 1'b0) $display("FAIL arst_ctrl got=%0d/%0d/%0d exp=0/0/0", out_valid, win_cnt, drop_flag); else passed++;
    checks++; if (avg_out !== 18'd0 || total_out !== 20'd0) $display("FAIL arst_data got=%0d/%0d exp=0/0", avg_out, total_out); else passed++;
    @(posedge clk); #1 rst_n = 1;
    for (int i = 0; i < 4; i++) cyc(1, 8, 1, 0);
    checks++; if (total_out !== 20'd32 || avg_out !== 18'd8) $display("FAIL arst_after got=%0d/%0d exp=32/8", total_out, avg_out); else passed++;
    cyc(0, 0, 1, 0);
  endtask

  task automatic test_random();
    logic [19:0] et;
    logic [17:0] ea;
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0,
          (($urandom % 4) == 0) ? 262143 - ($urandom % 4) : ($urandom % 1000),
          ($urandom % 3) == 0,
          ($urandom % 60) == 0);
      checks++; if (out_valid !== (m_tot.size() > 0)) $display("FAIL rnd_valid@%0d got=%0d exp=%0d", n, out_valid, m_tot.size() > 0); else passed++;
      checks++; if (win_cnt !== 2'(m_win.size())) $display("FAIL rnd_wincnt@%0d got=%0d exp=%0d", n, win_cnt, m_win.size()); else passed++;
      checks++; if (drop_flag !== m_drop) $display("FAIL rnd_drop@%0d got=%0d exp=%0d", n, drop_flag, m_drop); else passed++;
      if (m_tot.size() > 0 || m_last_ok) begin
        et = (m_tot.size() > 0) ? m_tot[0] : m_last_tot;
        ea = (m_avg.size() > 0) ? m_avg[0] : m_last_avg;
        checks++; if (total_out !== et || avg_out !== ea) $display("FAIL rnd_data@%0d got=%0d/%0d exp=%0d/%0d", n, total_out, avg_out, et, ea); else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max_gaps();
    test_drop();
    test_full_pushpop();
    test_clr();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
